// File: rtl/pixel_spi_packer.sv
// Packs 16-bit pixel words into 256-bit SPI beats (word 0 lowest); PIXEL_SPI_PACKER_BYTE_SWAP_EN swaps bytes of stored words.
// Latency: strobe one cycle after the closing accept when out_free is high; one HOLD cycle follows each strobe.
// Backpressure: in_ready is low outside FILL; a closed beat waits in SEND for out_free with out_data held.
module pixel_spi_packer #(
    parameter logic [15:0] FILL_WORD = 16'h0000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [15:0]  in_data,
    input  logic         in_last,
    input  logic         out_free,
    output logic         out_wr_en,
    output logic [255:0] out_data,
    output logic         frame_done,
    output logic [11:0]  beat_count
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  slot;
    logic        closed_by_last;
    logic [15:0] word_store;

    always_comb begin
        word_store = in_data;
`ifdef PIXEL_SPI_PACKER_BYTE_SWAP_EN
        word_store = {in_data[7:0], in_data[15:8]};
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= FILL;
            slot           <= 4'd0;
            closed_by_last <= 1'b0;
            in_ready       <= 1'b0;
            out_wr_en      <= 1'b0;
            frame_done     <= 1'b0;
            beat_count     <= 12'd0;
            out_data       <= '0;
        end else begin
            case (state)
                FILL: begin
                    in_ready   <= 1'b1;
                    out_wr_en  <= 1'b0;
                    frame_done <= 1'b0;
                    if (in_valid && in_ready) begin
                        // Padding is written raw: only upstream words are swapped.
                        for (int i = 0; i < 16; i++) begin
                            if (i[3:0] == slot)
                                out_data[16*i +: 16] <= word_store;
                            else if (in_last && (i[3:0] > slot))
                                out_data[16*i +: 16] <= FILL_WORD;
                        end
                        slot <= slot + 4'd1;
                        if (in_last || (slot == 4'd15)) begin
                            state          <= SEND;
                            in_ready       <= 1'b0;
                            closed_by_last <= in_last;
                        end
                    end
                end
                SEND: begin
                    in_ready <= 1'b0;
                    if (out_free) begin
                        out_wr_en <= 1'b1;
                        state     <= HOLD;
                        slot      <= 4'd0;
                        if (closed_by_last) begin
                            frame_done <= 1'b1;
                            beat_count <= 12'd0;
                        end else begin
                            beat_count <= beat_count + 12'd1;
                        end
                    end
                end
                HOLD: begin
                    // One dead cycle lets spi_slave drop its free flag before we look again.
                    out_wr_en  <= 1'b0;
                    frame_done <= 1'b0;
                    in_ready   <= 1'b1;
                    state      <= FILL;
                end
                default: begin
                    state     <= FILL;
                    in_ready  <= 1'b0;
                    out_wr_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_spi_packer.sv
// Randomized bench for pixel_spi_packer against a queue-based beat model.
module tb_pixel_spi_packer;

    localparam logic [15:0] FILL = 16'hFFFF;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [15:0]  in_data = '0;
    logic         in_last = 1'b0;
    logic         out_free = 1'b0;
    logic         out_wr_en;
    logic [255:0] out_data;
    logic         frame_done;
    logic [11:0]  beat_count;

    pixel_spi_packer #(.FILL_WORD(FILL)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_free   (out_free),
        .out_wr_en  (out_wr_en),
        .out_data   (out_data),
        .frame_done (frame_done),
        .beat_count (beat_count)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic        last;
        logic [15:0] data;
    } wd_t;

    wd_t          src[$];
    logic [15:0]  words[$];
    logic         closed, exp_wr, exp_rdy, exp_fd, pend_last, prev_wr;
    logic [255:0] exp_beat, last_wr_data;
    int           exp_bc, n_strobe, n_frame, n_adj, cyc, first_acc, strobe_cyc;
    logic         last_fd;
    int           last_bc;
    int           n_checks = 0;
    int           n_errors = 0;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sw(input logic [15:0] w);
`ifdef PIXEL_SPI_PACKER_BYTE_SWAP_EN
        return {w[7:0], w[15:8]};
`else
        return w;
`endif
    endfunction

    function automatic logic [255:0] build_beat();
        logic [255:0] b;
        for (int k = 0; k < 16; k++)
            b[16*k +: 16] = (k < words.size()) ? sw(words[k]) : FILL;
        return b;
    endfunction

    // One cycle: check outputs from the last edge, then drive and predict the next edge.
    task automatic step(input logic v, input logic [15:0] d, input logic l, input logic f, output logic acc);
        logic nxt_wr;
        @(negedge clk);
        cyc++;
        check_val("wr_en", out_wr_en, exp_wr);
        check_val("in_ready", in_ready, exp_rdy);
        check_val("frame_done", frame_done, exp_wr & exp_fd);
        if (out_wr_en && prev_wr) n_adj++;
        prev_wr = out_wr_en;
        if (exp_wr) begin
            check_val("beat_count", beat_count, exp_bc);
            check_val("wr_data", out_data, exp_beat);
        end
        if (closed) check_val("held_data", out_data, exp_beat);
        if (out_wr_en) begin
            n_strobe++;
            strobe_cyc   = cyc;
            last_wr_data = out_data;
            last_fd      = frame_done;
            last_bc      = beat_count;
            if (frame_done) n_frame++;
        end
        in_valid = v; in_data = d; in_last = l; out_free = f;
        acc    = exp_rdy && v;
        nxt_wr = closed && f;
        if (nxt_wr) begin
            closed = 1'b0;
            exp_fd = pend_last;
            exp_bc = pend_last ? 0 : (exp_bc + 1) % 4096;
        end
        if (acc) begin
            if (first_acc < 0) first_acc = cyc;
            words.push_back(d);
            if (l || words.size() == 16) begin
                closed    = 1'b1;
                pend_last = l;
                exp_beat  = build_beat();
                words.delete();
            end
        end
        exp_rdy = !closed && !nxt_wr;
        exp_wr  = nxt_wr;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_free = 1'b0;
        #1;
        check_val("rst_wr_en", out_wr_en, 0);
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_frame_done", frame_done, 0);
        check_val("rst_beat_count", beat_count, 0);
        check_val("rst_out_data", out_data, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1 check_val("rdy_before_edge", in_ready, 0);
        words.delete();
        closed = 1'b0; exp_wr = 1'b0; exp_rdy = 1'b1; exp_fd = 1'b0; exp_bc = 0; prev_wr = 1'b0;
    endtask

    task automatic drain(input int vp, input int fp, input int max_cyc);
        int   guard = 0;
        logic acc, v;
        while ((src.size() > 0 || closed || exp_wr) && guard < max_cyc) begin
            v = (src.size() > 0) && ($urandom_range(99) < vp);
            step(v, v ? src[0].data : 16'($urandom), v ? src[0].last : 1'($urandom),
                 $urandom_range(99) < fp, acc);
            if (acc) void'(src.pop_front());
            guard++;
        end
        check_val("drain_timeout", guard >= max_cyc, 0);
    endtask

    task automatic push_words(input int n, input int last_at, input logic [15:0] base);
        for (int i = 0; i < n; i++) src.push_back('{last: (i + 1 == last_at), data: base + 16'(i)});
    endtask

    initial begin
        logic         acc;
        logic [255:0] held;
        logic [255:0] ref_beat;
        int           s0;
        cyc = 0; first_acc = -1; n_strobe = 0; n_frame = 0; n_adj = 0;
        do_reset();

        // Sixteen sequential words with the consumer always free.
        push_words(16, 0, 16'h0000);
        drain(100, 100, 100);
        check_val("latency", strobe_cyc - first_acc, 17);
        check_val("w0", last_wr_data[15:0], sw(16'h0000));
        check_val("w15", last_wr_data[255:240], sw(16'h000F));
        check_val("bc_one", last_bc, 1);

        // Short frame padded with FILL.
        src.push_back('{last: 1'b0, data: 16'hA1A1});
        src.push_back('{last: 1'b0, data: 16'hB2B2});
        src.push_back('{last: 1'b1, data: 16'hC3C3});
        drain(100, 100, 100);
        check_val("short_low", last_wr_data[47:0], {sw(16'hC3C3), sw(16'hB2B2), sw(16'hA1A1)});
        check_val("short_pad", last_wr_data[255:48], {208{1'b1}});
        check_val("short_fd", last_fd, 1);
        check_val("short_bc", last_bc, 0);

        // Consumer busy for ten cycles after the beat closes.
        push_words(16, 0, 16'h5000);
        while (src.size() > 0) begin
            step(1'b1, src[0].data, 1'b0, 1'b0, acc);
            if (acc) void'(src.pop_front());
        end
        held = exp_beat;
        s0   = n_strobe;
        for (int i = 0; i < 10; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0, acc);
        check_val("stall_no_wr", n_strobe - s0, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0, 1'b1, acc);
        check_val("stall_one_wr", n_strobe - s0, 1);
        check_val("stall_data", last_wr_data, held);

        // Reset discards a partial beat.
        push_words(7, 0, 16'h7700);
        drain(100, 100, 20);
        s0 = n_strobe;
        do_reset();
        push_words(16, 0, 16'h9900);
        for (int k = 0; k < 16; k++) ref_beat[16*k +: 16] = sw(16'h9900 + 16'(k));
        drain(100, 100, 100);
        check_val("rst_one_wr", n_strobe - s0, 1);
        check_val("rst_clean_beat", last_wr_data, ref_beat);

        // Last flag on slot 15: full beat, no padding beat.
        s0 = n_strobe;
        push_words(16, 16, 16'h3300);
        drain(100, 100, 100);
        check_val("l15_wr", n_strobe - s0, 1);
        check_val("l15_fd", last_fd, 1);
        check_val("l15_bc", last_bc, 0);

        // Random traffic on both sides.
        for (int i = 0; i < 400; i++)
            src.push_back('{last: ($urandom_range(9) == 0), data: 16'($urandom)});
        src.push_back('{last: 1'b1, data: 16'h1234});
        drain(70, 60, 3000);

        // Long frame of 1800 words with continuous flow.
        n_strobe = 0; n_frame = 0; n_adj = 0;
        push_words(1800, 1800, 16'h0100);
        drain(100, 100, 4000);
        check_val("frame_strobes", n_strobe, 113);
        check_val("frame_dones", n_frame, 1);
        check_val("frame_pad", last_wr_data[255:128], {8{FILL}});
        check_val("no_adjacent", n_adj, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pixel_spi_packer.md
PIXEL_SPI_PACKER -- requirements
Module: pixel_spi_packer

Interface
REQ-001 Parameter FILL_WORD, default 16'h0000, pads unused word slots of a short final beat.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  reset is asynchronous and active-high.
REQ-004 in_valid  input  1  upstream pixel word present.
REQ-005 in_ready  output  1  block accepts in_data this cycle.
REQ-006 in_data  input  16  pixel word (2 bytes) read from image RAM.
REQ-007 in_last  input  1  qualifies in_data as last word of the image.
REQ-008 out_free  input  1  spi_slave wr_buffer_free.
REQ-009 out_wr_en  output  1  one-cycle write strobe to spi_slave wr_en.
REQ-010 out_data  output  256  32-byte beat to spi_slave wr_data.
REQ-011 frame_done  output  1  one-cycle pulse when the beat holding in_last is written.
REQ-012 beat_count  output  12  beats written since last frame_done or reset.

Function
REQ-013 The block shall have states FILL, SEND, HOLD.
REQ-014 Handshake: a word is accepted on a rising edge where in_valid=1 and in_ready=1; in_ready shall be 1 only in FILL.
REQ-015 The k-th accepted word of a beat (k=0..15) shall be placed at out_data[16k+15:16k]; word 0 in the lowest bits.
REQ-016 In FILL, a 4-bit slot index shall increment per accepted word; on accepting slot 15 or a word with in_last=1, the state shall go to SEND on that edge.
REQ-017 When a beat closes at slot k<15 via in_last, slots k+1..15 shall be loaded with FILL_WORD.
REQ-018 In SEND, on the first edge where out_free=1, out_wr_en shall be 1 for exactly the following cycle, state shall go to HOLD and slot index to 0.
REQ-019 out_data shall be registered and stable from the SEND entry until the next beat closes; it changes only on word acceptance.
REQ-020 HOLD shall last exactly one cycle (guard for spi_slave free-flag latency), then go to FILL; out_wr_en is thus never high on two consecutive cycles.
REQ-021 Minimum beat period: 16 acceptance cycles + 1 SEND + 1 HOLD = 18 cycles.
REQ-022 beat_count shall increment (wrapping at 4095 to 0) in the cycle out_wr_en is high.
REQ-023 If the written beat closed via in_last, frame_done shall pulse coincident with out_wr_en and beat_count shall become 0 instead of incrementing.
REQ-024 in_valid=0 in FILL shall hold state; a partial beat waits indefinitely without timeout.
REQ-025 in_last on slot 15 shall behave as a full beat plus frame_done; no extra padding beat.
REQ-026 out_free low in SEND shall stall indefinitely with out_data held and in_ready=0.

Reset
REQ-027 While reset=1: state=FILL, slot index=0, in_ready=0, out_wr_en=0, frame_done=0, beat_count=0, out_data=0.
REQ-028 in_ready shall rise on the first clock edge after reset deasserts.
REQ-029 Reset mid-beat or in SEND shall discard the partial beat with no write strobe issued.

Configuration
REQ-030 Macro PIXEL_SPI_PACKER_BYTE_SWAP_EN: when defined, each accepted word is stored as {in_data[7:0], in_data[15:8]}; when undefined, in_data is stored unmodified.
REQ-031 FILL_WORD padding shall never be byte-swapped.

Verification
REQ-032 Words 16'h0000..16'h000F, in_valid=1, out_free=1 -> single out_wr_en 17 cycles after first accept, out_data[15:0]=0000, out_data[255:240]=000F, beat_count=1.
REQ-033 Three words 16'hA1A1,16'hB2B2,16'hC3C3 with in_last on third, FILL_WORD=16'hFFFF -> out_data[47:0]=C3C3B2B2A1A1, bits [255:48] all 1, frame_done=1, beat_count=0.
REQ-034 Beat closed, out_free=0 for 10 cycles then 1 -> no out_wr_en and in_ready=0 for those 10 cycles, then one strobe, data unchanged.
REQ-035 reset pulsed after 7 words accepted -> no out_wr_en; next 16 words form a clean beat starting at slot 0.
REQ-036 With PIXEL_SPI_PACKER_BYTE_SWAP_EN defined, word 16'h1234 in slot 0 -> out_data[15:0]=16'h3412.
REQ-037 Continuous input, out_free=1, 1800 words with last on word 1800 -> 113 strobes, final beat has 8 data words + 8 FILL_WORD slots, one frame_done, strobes never adjacent.
